horizontal_rocket_pool: RTL

Multi-slot successor to the single horizontal enemy-rocket controller. It manages NUM_ROCKETS independent horizontal rockets and allocates each shoot request to the lowest free slot. A per-frame cooldown limits the fire rate. It sits between the enemy fire scheduler (shootPulse, randLoc) and the per-rocket movement/drawing instances, which consume initialX/Y/Speed on each slot's isActive rising edge.

---
 rtl/horizontal_rocket_pool.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/horizontal_rocket_pool.sv
// Multi-slot horizontal enemy-rocket pool: allocates launch requests to the
// lowest free slot, debounces border exits, and rate-limits with a frame cooldown.
module horizontal_rocket_pool #(
  parameter int NUM_ROCKETS     = 4,
  parameter int NUM_SPAWN       = 4,
  parameter int FIRE_SPEED      = 128,
  parameter int RIGHT_X         = 624,
  parameter int Y_BASE          = 450,
  parameter int LANE_STEP       = 32,
  parameter int COOLDOWN_FRAMES = 30,
  localparam int LOC_W = $clog2(NUM_SPAWN),
  localparam int CNT_W = $clog2(NUM_ROCKETS + 1)
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic                         isGameMode,
  input  logic                         shootPulse,
  input  logic [LOC_W-1:0]             randLoc,
  input  logic [NUM_ROCKETS-1:0]       reachedBorder,
  input  logic [NUM_ROCKETS-1:0]       rocketsCollision,
  input  logic [NUM_ROCKETS-1:0]       playerHitByRocket,
  output logic [NUM_ROCKETS-1:0]       isActiveHorizontal,
  output logic [NUM_ROCKETS-1:0][10:0] initialX,
  output logic [NUM_ROCKETS-1:0][10:0] initialY,
  output logic [NUM_ROCKETS-1:0][10:0] initialSpeed,
  output logic [NUM_ROCKETS-1:0]       launchPulse,
  output logic                         shotRejected,
  output logic [CNT_W-1:0]             activeCount
);

  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int HALF = NUM_SPAWN / 2;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  logic [NUM_ROCKETS-1:0]       active_q, active_d;
  logic [NUM_ROCKETS-1:0]       armed_q, armed_d;
  logic [NUM_ROCKETS-1:0]       border_dly_q;
  logic [NUM_ROCKETS-1:0]       kill;
  logic [NUM_ROCKETS-1:0]       free_sel, launch_vec;
  logic [NUM_ROCKETS-1:0]       launch_q;
  logic [NUM_ROCKETS-1:0][10:0] x_q, y_q, sp_q;
  logic [CD_W-1:0]              cool_q, cool_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         rej_q, rej_d;
  logic                         found, loc_valid, launch_ok;
  logic [10:0]                  spawn_x, spawn_y, spawn_sp;
  int                           loc_i, lane_i;

  // Spawn geometry: left half of the locations launch rightwards from X=0.
  always_comb begin
    loc_i     = int'(randLoc);
    lane_i    = loc_i % HALF;
    loc_valid = (loc_i < NUM_SPAWN);
    spawn_y   = 11'(Y_BASE - lane_i * LANE_STEP);
    if (loc_i < HALF) begin
      spawn_x  = 11'(0);
      spawn_sp = 11'(FIRE_SPEED);
    end else begin
      spawn_x  = 11'(RIGHT_X);
      spawn_sp = 11'(-FIRE_SPEED);
    end
  end

  always_comb begin
    free_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      if (!active_q[i] && !found) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
    launch_ok  = isGameMode && shootPulse && (cool_q == '0) && loc_valid && found;
    launch_vec = launch_ok ? free_sel : '0;
    rej_d      = isGameMode && shootPulse && !launch_ok;
  end

  // Border exits only count once armed, and need two consecutive border cycles.
  always_comb begin
    active_d = '0;
    armed_d  = '0;
    kill     = '0;
    cnt_d    = '0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      kill[i] = active_q[i] && (rocketsCollision[i] || playerHitByRocket[i] ||
                (armed_q[i] && reachedBorder[i] && border_dly_q[i]));
      active_d[i] = isGameMode && (launch_vec[i] || (active_q[i] && !kill[i]));
      armed_d[i]  = isGameMode && !launch_vec[i] && active_q[i] && !kill[i] &&
                    (armed_q[i] || startOfFrame);
      cnt_d = cnt_d + CNT_W'(active_d[i]);
    end
  end

  always_comb begin
    cool_d = cool_q;
    if (!isGameMode) cool_d = '0;
    else if (launch_ok) cool_d = CD_LOAD;
    else if (startOfFrame && (cool_q != '0)) cool_d = cool_q - CD_W'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_q     <= '0;
      armed_q      <= '0;
      border_dly_q <= '0;
      launch_q     <= '0;
      cool_q       <= '0;
      cnt_q        <= '0;
      rej_q        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      sp_q         <= '0;
    end else begin
      active_q     <= active_d;
      armed_q      <= armed_d;
      border_dly_q <= reachedBorder;
      launch_q     <= launch_vec;
      cool_q       <= cool_d;
      cnt_q        <= cnt_d;
      rej_q        <= rej_d;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
        if (launch_vec[i]) begin
          x_q[i]  <= spawn_x;
          y_q[i]  <= spawn_y;
          sp_q[i] <= spawn_sp;
        end
      end
    end
  end

  assign isActiveHorizontal = active_q;
  assign initialX           = x_q;
  assign initialY           = y_q;
  assign initialSpeed       = sp_q;
  assign launchPulse        = launch_q;
  assign shotRejected       = rej_q;
  assign activeCount        = cnt_q;

endmodule
